dma_bus_reader: RTL and testbench
=================================

DMA_BUS_READER -- requirements
Module: dma_bus_reader

Interface
REQ-001 SHALL have parameter MEM_ADDR_W, default 9, meaning local memory word-address width (512 words).
REQ-002 SHALL have parameter BLOCK_W, default 10, meaning block-size register width in words.
REQ-003 SHALL have parameter BURST_W, default 8, meaning burst-size field width (encoded as length minus 1).
REQ-004 SHALL have port clock  in  1  single system clock; all state rising-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port startTransfer  in  1  one-cycle pulse from the custom-instruction config block.
REQ-007 SHALL have port cfgBusStartAddr  in  32  byte address of first bus word; bits[1:0] ignored.
REQ-008 SHALL have port cfgMemStartAddr  in  MEM_ADDR_W  first local memory word address.
REQ-009 SHALL have port cfgBlockSize  in  BLOCK_W  number of words to move.
REQ-010 SHALL have port cfgBurstSize  in  BURST_W  maximum burst length minus 1.
REQ-011 SHALL have port statusBusy / statusError  out  1 / 1  transfer in progress / last transfer aborted.
REQ-012 SHALL have port transferDone  out  1  one-cycle pulse on completion or abort.
REQ-013 SHALL have port requestBus / busGrant  out / in  1 / 1  bus arbitration handshake.
REQ-014 SHALL have port beginTransactionOut, readNotWriteOut  out  1, 1  transaction start and direction.
REQ-015 SHALL have port addressDataOut / burstSizeOut  out  32 / BURST_W  burst address and length minus 1.
REQ-016 SHALL have port addressDataIn, dataValidIn, endTransactionIn, busErrorIn  in  32, 1, 1, 1  slave read data and control.
REQ-017 SHALL have port memWe, memAddr, memWdata  out  1, MEM_ADDR_W, 32  write port to the DMA local memory.

Function
REQ-018 SHALL implement FSM states IDLE, REQUEST, BEGIN, DATA, DONE.
REQ-019 In IDLE, startTransfer SHALL latch all cfg* inputs; blockSize 0 SHALL go directly to DONE without requesting the bus; otherwise -> REQUEST.
REQ-020 startTransfer outside IDLE SHALL be ignored; config changes mid-transfer SHALL have no effect.
REQ-021 REQUEST SHALL assert requestBus; on busGrant -> BEGIN.
REQ-022 BEGIN SHALL last exactly one cycle with beginTransactionOut=1, readNotWriteOut=1, addressDataOut=current bus address, burstSizeOut=min(burst+1, remaining)-1; then -> DATA.
REQ-023 All bus outputs other than requestBus SHALL be 0 outside BEGIN (wired-OR bus).
REQ-024 requestBus SHALL stay asserted from REQUEST until the cycle endTransactionIn or busErrorIn is seen.
REQ-025 In DATA, each dataValidIn SHALL produce memWe=1, memWdata=addressDataIn, memAddr=current memory address in the same cycle; memory address +1 and bus address +4 per word, remaining -1.
REQ-026 Memory address SHALL wrap modulo 2^MEM_ADDR_W; bus address SHALL wrap modulo 2^32.
REQ-027 On endTransactionIn in DATA: remaining>0 -> REQUEST (bus released for one cycle minimum); remaining==0 -> DONE.
REQ-028 dataValidIn and endTransactionIn in the same cycle SHALL store the word before evaluating remaining.
REQ-029 busErrorIn in BEGIN or DATA SHALL drop requestBus, set statusError, suppress memWe that cycle, -> DONE.
REQ-030 DONE SHALL pulse transferDone for one cycle, then -> IDLE; statusBusy=1 in every state except IDLE.
REQ-031 statusError SHALL be sticky until the next accepted startTransfer clears it.
REQ-032 Latency: startTransfer at cycle N -> requestBus high at N+1.

Reset
REQ-033 reset low SHALL asynchronously force IDLE, clear all counters/latched config, and drive every output to 0.
REQ-034 Reset mid-transfer SHALL abort without transferDone pulse; no memWe after reset assertion.

Structure
REQ-035 Package dma_pkg SHALL hold the FSM state type and the MEM_ADDR_W/BLOCK_W/BURST_W defaults shared with the DMA config block.
REQ-036 Single module; no sub-module required.

Verification
REQ-037 Block 0: start, blockSize=0 -> no requestBus, transferDone at N+1, statusError=0.
REQ-038 Block 8, burst 7 (8 words), bus 0x1000, mem 0x010 -> one BEGIN with burstSizeOut=7, words written to mem 0x010..0x017, done pulse.
REQ-039 Block 10, burst 3 -> three BEGINs at 0x1000/0x1010/0x1020 with burstSizeOut 3,3,1; requestBus drops between bursts.
REQ-040 mem start 0x1FE, block 4 -> writes to 0x1FE,0x1FF,0x000,0x001.
REQ-041 busErrorIn on 2nd word of 4 -> only 1 memWe, statusError=1, done pulse; next start clears statusError.
REQ-042 reset low during DATA -> all outputs 0 immediately, IDLE, no transferDone.

Source files
------------

// File: rtl/dma_bus_reader_pkg.sv
// Shared DMA definitions: FSM state type and default widths used by the
// bus reader and the DMA configuration block.
package dma_pkg;

    localparam int MEM_ADDR_W_DEFAULT = 9;   // 512-word local memory
    localparam int BLOCK_W_DEFAULT    = 10;  // block-size register width
    localparam int BURST_W_DEFAULT    = 8;   // burst length minus 1

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        BEGIN,
        DATA,
        DONE
    } dmaState_e;

endpackage

// File: rtl/dma_bus_reader_if.sv
// Shared bus handshake between the DMA reader (master) and the bus/slave side.
interface dma_bus_reader_if
    import dma_pkg::*;
#(
    parameter int BURST_W = BURST_W_DEFAULT
);

    logic               requestBus;
    logic               busGrant;
    logic               beginTransactionOut;
    logic               readNotWriteOut;
    logic [31:0]        addressDataOut;
    logic [BURST_W-1:0] burstSizeOut;
    logic [31:0]        addressDataIn;
    logic               dataValidIn;
    logic               endTransactionIn;
    logic               busErrorIn;

    modport master (
        output requestBus,
        output beginTransactionOut,
        output readNotWriteOut,
        output addressDataOut,
        output burstSizeOut,
        input  busGrant,
        input  addressDataIn,
        input  dataValidIn,
        input  endTransactionIn,
        input  busErrorIn
    );

    modport slave (
        input  requestBus,
        input  beginTransactionOut,
        input  readNotWriteOut,
        input  addressDataOut,
        input  burstSizeOut,
        output busGrant,
        output addressDataIn,
        output dataValidIn,
        output endTransactionIn,
        output busErrorIn
    );

endinterface

// File: rtl/dma_bus_reader.sv
// DMA bus reader: splits a block read into bursts on the shared bus and
// writes every returned word into the DMA local memory.
module dma_bus_reader
    import dma_pkg::*;
#(
    parameter int MEM_ADDR_W = MEM_ADDR_W_DEFAULT,
    parameter int BLOCK_W    = BLOCK_W_DEFAULT,
    parameter int BURST_W    = BURST_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  startTransfer,
    input  logic [31:0]           cfgBusStartAddr,
    input  logic [MEM_ADDR_W-1:0] cfgMemStartAddr,
    input  logic [BLOCK_W-1:0]    cfgBlockSize,
    input  logic [BURST_W-1:0]    cfgBurstSize,
    output logic                  statusBusy,
    output logic                  statusError,
    output logic                  transferDone,
    dma_bus_reader_if.master      bus,
    output logic                  memWe,
    output logic [MEM_ADDR_W-1:0] memAddr,
    output logic [31:0]           memWdata
);

    // Wide enough for both burst+1 and the remaining word count.
    localparam int LEN_W = (BURST_W + 1 > BLOCK_W) ? BURST_W + 1 : BLOCK_W;

    dmaState_e             state, nextState;
    logic [31:0]           busAddr;
    logic [MEM_ADDR_W-1:0] memAddrReg;
    logic [BLOCK_W-1:0]    remaining;
    logic [BLOCK_W-1:0]    remainingAfter;
    logic [BURST_W-1:0]    burstCfg;
    logic                  errorReg;

    logic                  startAccepted;
    logic                  storeWord;
    logic                  setError;

    logic [LEN_W-1:0]      burstLen;
    logic [LEN_W-1:0]      remainLen;
    logic [LEN_W-1:0]      thisLen;
    logic [BURST_W-1:0]    burstField;

    // State register, latched configuration and transfer counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busAddr    <= '0;
            memAddrReg <= '0;
            remaining  <= '0;
            burstCfg   <= '0;
            errorReg   <= 1'b0;
        end else begin
            state <= nextState;
            if (startAccepted) begin
                busAddr    <= cfgBusStartAddr & ~32'd3;
                memAddrReg <= cfgMemStartAddr;
                remaining  <= cfgBlockSize;
                burstCfg   <= cfgBurstSize;
                errorReg   <= 1'b0;
            end
            if (storeWord) begin
                busAddr    <= busAddr + 32'd4;
                memAddrReg <= memAddrReg + MEM_ADDR_W'(1);
                remaining  <= remainingAfter;
            end
            if (setError) begin
                errorReg <= 1'b1;
            end
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        nextState      = state;
        startAccepted  = 1'b0;
        storeWord      = 1'b0;
        setError       = 1'b0;
        remainingAfter = remaining;
        case (state)
            IDLE: begin
                if (startTransfer) begin
                    startAccepted = 1'b1;
                    nextState     = (cfgBlockSize == '0) ? DONE : REQUEST;
                end
            end
            REQUEST: begin
                if (bus.busGrant) begin
                    nextState = BEGIN;
                end
            end
            BEGIN: begin
                if (bus.busErrorIn) begin
                    setError  = 1'b1;
                    nextState = DONE;
                end else begin
                    nextState = DATA;
                end
            end
            DATA: begin
                if (bus.busErrorIn) begin
                    setError  = 1'b1;
                    nextState = DONE;
                end else begin
                    // A word arriving with endTransactionIn counts before the
                    // remaining check.
                    storeWord      = bus.dataValidIn;
                    remainingAfter = remaining - BLOCK_W'(storeWord);
                    if (bus.endTransactionIn) begin
                        nextState = (remainingAfter == '0) ? DONE : REQUEST;
                    end
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Burst length for this BEGIN: min(burst+1, remaining) encoded minus 1.
    always_comb begin
        burstLen   = LEN_W'(burstCfg) + LEN_W'(1);
        remainLen  = LEN_W'(remaining);
        thisLen    = (burstLen < remainLen) ? burstLen : remainLen;
        burstField = BURST_W'(thisLen - LEN_W'(1));
    end

    // Status and memory write port; data/address gated so idle outputs are 0.
    always_comb begin
        statusBusy   = (state != IDLE);
        statusError  = errorReg;
        transferDone = (state == DONE);
        memWe        = storeWord;
        memAddr      = storeWord ? memAddrReg : '0;
        memWdata     = storeWord ? bus.addressDataIn : '0;
    end

    // requestBus falls in the cycle the slave ends or errors the burst.
    assign bus.requestBus          = (state == REQUEST) ||
                                     (((state == BEGIN) || (state == DATA)) &&
                                      !bus.endTransactionIn && !bus.busErrorIn);
    assign bus.beginTransactionOut = (state == BEGIN);
    assign bus.readNotWriteOut     = (state == BEGIN);
    assign bus.addressDataOut      = (state == BEGIN) ? busAddr : '0;
    assign bus.burstSizeOut        = (state == BEGIN) ? burstField : '0;

endmodule

// File: tb/tb_dma_bus_reader.sv
// Directed testbench for dma_bus_reader.
module tb_dma_bus_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        startTransfer;
    logic [31:0] cfgBusStartAddr;
    logic [8:0]  cfgMemStartAddr;
    logic [9:0]  cfgBlockSize;
    logic [7:0]  cfgBurstSize;
    logic        statusBusy;
    logic        statusError;
    logic        transferDone;
    logic        memWe;
    logic [8:0]  memAddr;
    logic [31:0] memWdata;

    int compared   = 0;
    int mismatched = 0;

    dma_bus_reader_if #(.BURST_W(8)) bus ();

    dma_bus_reader #(
        .MEM_ADDR_W(9),
        .BLOCK_W   (10),
        .BURST_W   (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .startTransfer  (startTransfer),
        .cfgBusStartAddr(cfgBusStartAddr),
        .cfgMemStartAddr(cfgMemStartAddr),
        .cfgBlockSize   (cfgBlockSize),
        .cfgBurstSize   (cfgBurstSize),
        .statusBusy     (statusBusy),
        .statusError    (statusError),
        .transferDone   (transferDone),
        .bus            (bus),
        .memWe          (memWe),
        .memAddr        (memAddr),
        .memWdata       (memWdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic startXfer(input logic [31:0] busA, input logic [8:0] memA,
                             input logic [9:0] blk, input logic [7:0] burst);
        cfgBusStartAddr = busA;
        cfgMemStartAddr = memA;
        cfgBlockSize    = blk;
        cfgBurstSize    = burst;
        startTransfer   = 1'b1;
        tick();
        startTransfer   = 1'b0;
    endtask

    // Entered with the DUT in REQUEST; grants, checks BEGIN, returns nWords.
    task automatic doBurst(input logic [31:0] expAddr, input logic [7:0] expSize,
                           input int nWords, input logic [8:0] expMem0,
                           input logic [31:0] data0, input bit expDone);
        logic [8:0] m;
        bus.dataValidIn      = 1'b0;
        bus.endTransactionIn = 1'b0;
        #1;
        chk("reqBeforeGrant", bus.requestBus, 1);
        chk("noBeginInRequest", bus.beginTransactionOut, 0);
        bus.busGrant = 1'b1;
        tick();
        bus.busGrant = 1'b0;
        #1;
        chk("beginOut", bus.beginTransactionOut, 1);
        chk("readNotWrite", bus.readNotWriteOut, 1);
        chk("beginAddr", bus.addressDataOut, expAddr);
        chk("beginBurstSize", bus.burstSizeOut, expSize);
        chk("reqInBegin", bus.requestBus, 1);
        tick();
        for (int w = 0; w < nWords; w++) begin
            bus.dataValidIn      = 1'b1;
            bus.addressDataIn    = data0 + w;
            bus.endTransactionIn = (w == nWords - 1);
            m = expMem0 + 9'(w);
            #1;
            chk("memWe", memWe, 1);
            chk("memAddr", memAddr, m);
            chk("memWdata", memWdata, data0 + w);
            chk("addrOutInData", bus.addressDataOut, 0);
            if (w == nWords - 1) chk("reqDropAtEnd", bus.requestBus, 0);
            tick();
        end
        bus.dataValidIn      = 1'b0;
        bus.endTransactionIn = 1'b0;
        bus.addressDataIn    = '0;
        #1;
        chk("doneAfterBurst", transferDone, expDone);
        chk("busyAfterBurst", statusBusy, 1);
        chk("memWeIdle", memWe, 0);
    endtask

    initial begin
        reset                = 1'b0;
        startTransfer        = 1'b0;
        cfgBusStartAddr      = '0;
        cfgMemStartAddr      = '0;
        cfgBlockSize         = '0;
        cfgBurstSize         = '0;
        bus.busGrant         = 1'b0;
        bus.addressDataIn    = '0;
        bus.dataValidIn      = 1'b0;
        bus.endTransactionIn = 1'b0;
        bus.busErrorIn       = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rstBusy", statusBusy, 0);
        chk("rstError", statusError, 0);
        chk("rstDone", transferDone, 0);
        chk("rstReq", bus.requestBus, 0);
        chk("rstBegin", bus.beginTransactionOut, 0);
        chk("rstMemWe", memWe, 0);
        reset = 1'b1;
        tick();

        // Block size 0: straight to DONE, no bus request
        startXfer(32'h0000_1000, 9'h010, 10'd0, 8'd7);
        #1;
        chk("blk0Done", transferDone, 1);
        chk("blk0NoReq", bus.requestBus, 0);
        chk("blk0Busy", statusBusy, 1);
        chk("blk0Error", statusError, 0);
        tick();
        chk("blk0DoneOnePulse", transferDone, 0);
        chk("blk0Idle", statusBusy, 0);

        // Block 8, burst 7; config changes and a second start are ignored
        startXfer(32'h0000_1000, 9'h010, 10'd8, 8'd7);
        cfgBusStartAddr = 32'h5555_0000;
        cfgMemStartAddr = 9'h155;
        cfgBlockSize    = 10'd3;
        cfgBurstSize    = 8'd0;
        startTransfer   = 1'b1;
        #1;
        chk("latencyReq", bus.requestBus, 1);
        tick();
        startTransfer = 1'b0;
        doBurst(32'h0000_1000, 8'd7, 8, 9'h010, 32'hA000_0000, 1'b1);
        tick();
        chk("b8DoneOnePulse", transferDone, 0);
        chk("b8Idle", statusBusy, 0);

        // Block 10, burst 3: three bursts of 4,4,2
        startXfer(32'h0000_1000, 9'h040, 10'd10, 8'd3);
        doBurst(32'h0000_1000, 8'd3, 4, 9'h040, 32'hB000_0000, 1'b0);
        doBurst(32'h0000_1010, 8'd3, 4, 9'h044, 32'hB000_0004, 1'b0);
        doBurst(32'h0000_1020, 8'd1, 2, 9'h048, 32'hB000_0008, 1'b1);
        tick();
        chk("b10Idle", statusBusy, 0);

        // Memory and bus address wrap; bus address low bits ignored
        startXfer(32'hFFFF_FFFB, 9'h1FE, 10'd4, 8'd1);
        doBurst(32'hFFFF_FFF8, 8'd1, 2, 9'h1FE, 32'hC000_0000, 1'b0);
        doBurst(32'h0000_0000, 8'd1, 2, 9'h000, 32'hC000_0002, 1'b1);
        tick();

        // Bus error on the second word
        startXfer(32'h0000_2000, 9'h080, 10'd4, 8'd3);
        bus.busGrant = 1'b1;
        tick();
        bus.busGrant = 1'b0;
        tick();
        bus.dataValidIn   = 1'b1;
        bus.addressDataIn = 32'hD000_0000;
        #1;
        chk("errWord0We", memWe, 1);
        chk("errWord0Addr", memAddr, 9'h080);
        tick();
        bus.addressDataIn = 32'hD000_0001;
        bus.busErrorIn    = 1'b1;
        #1;
        chk("errSuppressWe", memWe, 0);
        chk("errDropReq", bus.requestBus, 0);
        tick();
        bus.dataValidIn = 1'b0;
        bus.busErrorIn  = 1'b0;
        #1;
        chk("errDone", transferDone, 1);
        chk("errFlag", statusError, 1);
        tick();
        chk("errSticky", statusError, 1);
        chk("errIdle", statusBusy, 0);
        startXfer(32'h0, 9'h0, 10'd0, 8'd0);
        #1;
        chk("errClearedByStart", statusError, 0);
        tick();

        // Reset in the middle of DATA
        startXfer(32'h0000_3000, 9'h0C0, 10'd4, 8'd3);
        bus.busGrant = 1'b1;
        tick();
        bus.busGrant = 1'b0;
        tick();
        bus.dataValidIn   = 1'b1;
        bus.addressDataIn = 32'hE000_0000;
        #1;
        chk("preRstWe", memWe, 1);
        reset = 1'b0;
        #1;
        chk("midRstWe", memWe, 0);
        chk("midRstAddr", memAddr, 0);
        chk("midRstWdata", memWdata, 0);
        chk("midRstReq", bus.requestBus, 0);
        chk("midRstBusy", statusBusy, 0);
        chk("midRstDone", transferDone, 0);
        tick();
        chk("rstHoldDone", transferDone, 0);
        chk("rstHoldWe", memWe, 0);
        bus.dataValidIn = 1'b0;
        reset = 1'b1;
        tick();
        chk("postRstDone", transferDone, 0);
        chk("postRstBusy", statusBusy, 0);
        chk("postRstReq", bus.requestBus, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
